control_sequencer: RTL and testbench

Microcode sequencer for the 8-bit breadboard-style CPU. It sits directly downstream of the clock/step block. It takes a one-cycle CPU-step strobe plus the instruction-register opcode and ALU flags, and holds the 5-step T-state counter. It produces the registered 16-bit control word that drives every bus enable and load in the datapath, and it returns the halt/run line that gates the CPU clock.

---
 rtl/ctrl_pkg.sv | 64 ++++++
 rtl/microcode_rom.sv | 62 ++++++
 rtl/control_sequencer.sv | 81 ++++++++
 tb/tb_control_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants and types for the 8-bit CPU microcode sequencer.
// Control-bit indices, opcodes, T-state limits and the control-word type.
package ctrl_pkg;

    localparam int unsigned CW_W   = 16;
    localparam int unsigned OP_W   = 4;
    localparam int unsigned STEP_W = 3;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Control-word bit positions, MSB first
    localparam int unsigned HLT_BIT = 15;
    localparam int unsigned MI_BIT  = 14;
    localparam int unsigned RI_BIT  = 13;
    localparam int unsigned RO_BIT  = 12;
    localparam int unsigned IO_BIT  = 11;
    localparam int unsigned II_BIT  = 10;
    localparam int unsigned AI_BIT  = 9;
    localparam int unsigned AO_BIT  = 8;
    localparam int unsigned EO_BIT  = 7;
    localparam int unsigned SU_BIT  = 6;
    localparam int unsigned BI_BIT  = 5;
    localparam int unsigned OI_BIT  = 4;
    localparam int unsigned CE_BIT  = 3;
    localparam int unsigned CO_BIT  = 2;
    localparam int unsigned J_BIT   = 1;
    localparam int unsigned FI_BIT  = 0;

    localparam ctrl_word_t CW_HLT = ctrl_word_t'(1) << HLT_BIT;
    localparam ctrl_word_t CW_MI  = ctrl_word_t'(1) << MI_BIT;
    localparam ctrl_word_t CW_RI  = ctrl_word_t'(1) << RI_BIT;
    localparam ctrl_word_t CW_RO  = ctrl_word_t'(1) << RO_BIT;
    localparam ctrl_word_t CW_IO  = ctrl_word_t'(1) << IO_BIT;
    localparam ctrl_word_t CW_II  = ctrl_word_t'(1) << II_BIT;
    localparam ctrl_word_t CW_AI  = ctrl_word_t'(1) << AI_BIT;
    localparam ctrl_word_t CW_AO  = ctrl_word_t'(1) << AO_BIT;
    localparam ctrl_word_t CW_EO  = ctrl_word_t'(1) << EO_BIT;
    localparam ctrl_word_t CW_SU  = ctrl_word_t'(1) << SU_BIT;
    localparam ctrl_word_t CW_BI  = ctrl_word_t'(1) << BI_BIT;
    localparam ctrl_word_t CW_OI  = ctrl_word_t'(1) << OI_BIT;
    localparam ctrl_word_t CW_CE  = ctrl_word_t'(1) << CE_BIT;
    localparam ctrl_word_t CW_CO  = ctrl_word_t'(1) << CO_BIT;
    localparam ctrl_word_t CW_J   = ctrl_word_t'(1) << J_BIT;
    localparam ctrl_word_t CW_FI  = ctrl_word_t'(1) << FI_BIT;

    localparam logic [OP_W-1:0] OP_NOP = 4'h0;
    localparam logic [OP_W-1:0] OP_LDA = 4'h1;
    localparam logic [OP_W-1:0] OP_ADD = 4'h2;
    localparam logic [OP_W-1:0] OP_SUB = 4'h3;
    localparam logic [OP_W-1:0] OP_STA = 4'h4;
    localparam logic [OP_W-1:0] OP_LDI = 4'h5;
    localparam logic [OP_W-1:0] OP_JMP = 4'h6;
    localparam logic [OP_W-1:0] OP_JC  = 4'h7;
    localparam logic [OP_W-1:0] OP_JZ  = 4'h8;
    localparam logic [OP_W-1:0] OP_OUT = 4'hE;
    localparam logic [OP_W-1:0] OP_HLT = 4'hF;

    localparam logic [STEP_W-1:0] STEP_FETCH  = 3'd0;
    localparam logic [STEP_W-1:0] STEP_DECODE = 3'd1;
    localparam logic [STEP_W-1:0] STEP_EXEC   = 3'd2;
    localparam logic [STEP_W-1:0] STEP_EXEC2  = 3'd3;
    localparam logic [STEP_W-1:0] STEP_LAST   = 3'd4;

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode ROM: (T-state, opcode, flags) -> 16-bit control word.
module microcode_rom
    import ctrl_pkg::*;
(
    input  logic [STEP_W-1:0] step,
    input  logic [OP_W-1:0]   opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output ctrl_word_t        word_c
);

    ctrl_word_t exec2_c;
    ctrl_word_t exec3_c;
    ctrl_word_t exec4_c;

    // Per-opcode execute words for T2/T3/T4; unlisted opcodes stay all-zero
    always_comb begin
        exec2_c = '0;
        exec3_c = '0;
        exec4_c = '0;
        case (opcode)
            OP_LDA: begin
                exec2_c = CW_MI | CW_IO;
                exec3_c = CW_RO | CW_AI;
            end
            OP_ADD: begin
                exec2_c = CW_MI | CW_IO;
                exec3_c = CW_RO | CW_BI;
                exec4_c = CW_AI | CW_EO | CW_FI;
            end
            OP_SUB: begin
                exec2_c = CW_MI | CW_IO;
                exec3_c = CW_RO | CW_BI;
                exec4_c = CW_AI | CW_EO | CW_SU | CW_FI;
            end
            OP_STA: begin
                exec2_c = CW_MI | CW_IO;
                exec3_c = CW_RI | CW_AO;
            end
            OP_LDI: exec2_c = CW_IO | CW_AI;
            OP_JMP: exec2_c = CW_IO | CW_J;
            OP_JC:  exec2_c = flag_c ? (CW_IO | CW_J) : '0;
            OP_JZ:  exec2_c = flag_z ? (CW_IO | CW_J) : '0;
            OP_OUT: exec2_c = CW_AO | CW_OI;
            OP_HLT: exec2_c = CW_HLT;
            default: ;
        endcase
    end

    always_comb begin
        word_c = '0;
        case (step)
            STEP_FETCH:  word_c = CW_MI | CW_CO;
            STEP_DECODE: word_c = CW_RO | CW_II | CW_CE;
            STEP_EXEC:   word_c = exec2_c;
            STEP_EXEC2:  word_c = exec3_c;
            STEP_LAST:   word_c = exec4_c;
            default:     word_c = '0;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: T-state counter, registered control word, halt/run
// and instruction-done pulse for the 8-bit breadboard CPU.
module control_sequencer
    import ctrl_pkg::*;
(
    input  logic              system_clock,
    input  logic              clr_n,
    input  logic              tick,
    input  logic [OP_W-1:0]   opcode,
    input  logic              flag_c,
    input  logic              flag_z,
    output logic [CW_W-1:0]   ctrl_word,
    output logic [STEP_W-1:0] step,
    output logic              instr_done,
    output logic              run
);

    logic [STEP_W-1:0] step_q, step_d;
    ctrl_word_t        ctrl_word_q, ctrl_word_d;
    logic              instr_done_q, instr_done_d;
    logic              run_q, run_d;
    logic              halted_q, halted_d;
    logic              guard_q, guard_d;
    ctrl_word_t        rom_word_c;
    logic              accept_c;

    microcode_rom u_rom (
        .step   (step_q),
        .opcode (opcode),
        .flag_c (flag_c),
        .flag_z (flag_z),
        .word_c (rom_word_c)
    );

    // Guard drops a tick landing before ctrl_word has caught up with step
    assign accept_c = tick & ~guard_q & ~halted_q;

    always_comb begin
        step_d       = step_q;
        ctrl_word_d  = rom_word_c;
        instr_done_d = 1'b0;
        halted_d     = halted_q;
        guard_d      = accept_c;
        if (accept_c) begin
            if (ctrl_word_q[HLT_BIT]) begin
                halted_d = 1'b1;
            end else if ((step_q == STEP_LAST) ||
                         ((step_q >= STEP_EXEC) && (ctrl_word_q == '0))) begin
                step_d       = STEP_FETCH;
                instr_done_d = 1'b1;
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end
        run_d = ~halted_d;
    end

    always_ff @(posedge system_clock or negedge clr_n) begin
        if (!clr_n) begin
            step_q       <= STEP_FETCH;
            ctrl_word_q  <= '0;
            instr_done_q <= 1'b0;
            run_q        <= 1'b1;
            halted_q     <= 1'b0;
            guard_q      <= 1'b0;
        end else begin
            step_q       <= step_d;
            ctrl_word_q  <= ctrl_word_d;
            instr_done_q <= instr_done_d;
            run_q        <= run_d;
            halted_q     <= halted_d;
            guard_q      <= guard_d;
        end
    end

    assign ctrl_word  = ctrl_word_q;
    assign step       = step_q;
    assign instr_done = instr_done_q;
    assign run        = run_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-opcode vector table plus
// hand-written halt, reset and back-to-back tick sequences.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr_n;
    logic        tick;
    logic [3:0]  opcode;
    logic        flag_c;
    logic        flag_z;
    logic [15:0] ctrl_word;
    logic [2:0]  step;
    logic        instr_done;
    logic        run;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  op;
        logic        fc;
        logic        fz;
        logic [15:0] w2;
        logic [15:0] w3;
        logic [15:0] w4;
        int          len;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    control_sequencer dut (
        .system_clock (clk),
        .clr_n        (clr_n),
        .tick         (tick),
        .opcode       (opcode),
        .flag_c       (flag_c),
        .flag_z       (flag_z),
        .ctrl_word    (ctrl_word),
        .step         (step),
        .instr_done   (instr_done),
        .run          (run)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One-cycle tick seen by exactly one rising edge; returns #1 after that edge
    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic tick_settle();
        pulse_tick();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word_for(input int s, input vec_t v);
        case (s)
            0: return 16'h4004;
            1: return 16'h1408;
            2: return v.w2;
            3: return v.w3;
            4: return v.w4;
            default: return 16'h0000;
        endcase
    endfunction

    initial begin
        int exp_step;
        vecs[0]  = '{4'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 16'h4800, 16'h1200, 16'h0000, 5};
        vecs[2]  = '{4'h2, 1'b0, 1'b0, 16'h4800, 16'h1020, 16'h0281, 5};
        vecs[3]  = '{4'h3, 1'b0, 1'b0, 16'h4800, 16'h1020, 16'h02C1, 5};
        vecs[4]  = '{4'h4, 1'b0, 1'b0, 16'h4800, 16'h2100, 16'h0000, 5};
        vecs[5]  = '{4'h5, 1'b0, 1'b0, 16'h0A00, 16'h0000, 16'h0000, 4};
        vecs[6]  = '{4'h6, 1'b0, 1'b0, 16'h0802, 16'h0000, 16'h0000, 4};
        vecs[7]  = '{4'h7, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3};
        vecs[8]  = '{4'h7, 1'b1, 1'b0, 16'h0802, 16'h0000, 16'h0000, 4};
        vecs[9]  = '{4'h8, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h0000, 3};
        vecs[10] = '{4'h8, 1'b0, 1'b1, 16'h0802, 16'h0000, 16'h0000, 4};
        vecs[11] = '{4'h9, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3};
        vecs[12] = '{4'hD, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0000, 3};
        vecs[13] = '{4'hE, 1'b0, 1'b0, 16'h0110, 16'h0000, 16'h0000, 4};
        vecs[14] = '{4'h2, 1'b1, 1'b1, 16'h4800, 16'h1020, 16'h0281, 5};
        vecs[15] = '{4'h6, 1'b1, 1'b1, 16'h0802, 16'h0000, 16'h0000, 4};

        clr_n  = 1'b0;
        tick   = 1'b0;
        opcode = 4'h0;
        flag_c = 1'b0;
        flag_z = 1'b0;

        // Reset state while held, then first fetch word after release
        repeat (3) @(posedge clk);
        #1;
        check("rst_step", 16'(step), 16'd0);
        check("rst_word", ctrl_word, 16'h0000);
        check("rst_run", 16'(run), 16'd1);
        check("rst_done", 16'(instr_done), 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_word", ctrl_word, 16'h4004);
        check("post_rst_step", 16'(step), 16'd0);
        check("post_rst_run", 16'(run), 16'd1);
        check("post_rst_done", 16'(instr_done), 16'd0);

        // Table: walk each opcode through a full instruction
        for (int v = 0; v < NVEC; v++) begin
            opcode = vecs[v].op;
            flag_c = vecs[v].fc;
            flag_z = vecs[v].fz;
            repeat (2) @(posedge clk);
            #1;
            check("vec_fetch_word", ctrl_word, 16'h4004);
            check("vec_run", 16'(run), 16'd1);
            for (int k = 1; k <= vecs[v].len; k++) begin
                pulse_tick();
                exp_step = (k < vecs[v].len) ? k : 0;
                check("vec_step", 16'(step), 16'(exp_step));
                check("vec_done_pulse", 16'(instr_done), (k == vecs[v].len) ? 16'd1 : 16'd0);
                @(posedge clk);
                #1;
                check("vec_word", ctrl_word, word_for(exp_step, vecs[v]));
                check("vec_done_low", 16'(instr_done), 16'd0);
                repeat (2) @(posedge clk);
                #1;
            end
        end

        // Halt: HLT stalls at step 2 and drops run; ticks ignored until reset
        do_reset();
        opcode = 4'hF;
        flag_c = 1'b0;
        flag_z = 1'b0;
        tick_settle();
        tick_settle();
        check("hlt_step2", 16'(step), 16'd2);
        check("hlt_word", ctrl_word, 16'h8000);
        check("hlt_run_before", 16'(run), 16'd1);
        pulse_tick();
        check("hlt_run_low", 16'(run), 16'd0);
        check("hlt_step_hold", 16'(step), 16'd2);
        check("hlt_no_done", 16'(instr_done), 16'd0);
        repeat (3) @(posedge clk);
        #1;
        tick_settle();
        tick_settle();
        check("hlt_frozen_step", 16'(step), 16'd2);
        check("hlt_frozen_word", ctrl_word, 16'h8000);
        check("hlt_still_low", 16'(run), 16'd0);
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("hlt_rst_run", 16'(run), 16'd1);
        check("hlt_rst_step", 16'(step), 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset during ADD step 3 aborts at once; fetch word one cycle after release
        opcode = 4'h2;
        tick_settle();
        tick_settle();
        tick_settle();
        check("add_step3", 16'(step), 16'd3);
        check("add_word3", ctrl_word, 16'h1020);
        @(negedge clk);
        clr_n = 1'b0;
        #1;
        check("mid_rst_step", 16'(step), 16'd0);
        check("mid_rst_word", ctrl_word, 16'h0000);
        check("mid_rst_done", 16'(instr_done), 16'd0);
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_fetch", ctrl_word, 16'h4004);

        // Back-to-back ticks: only the first is accepted
        opcode = 4'h1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tick = 1'b0;
        #1;
        check("b2b_step", 16'(step), 16'd1);
        @(posedge clk);
        #1;
        check("b2b_word", ctrl_word, 16'h1408);
        repeat (2) @(posedge clk);
        tick_settle();
        check("b2b_next_step", 16'(step), 16'd2);
        check("b2b_next_word", ctrl_word, 16'h4800);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
